// File: rtl/param_write_arbiter.sv
// rtl/param_write_arbiter.sv - round-robin write arbiter/sequencer for the effect-parameter bank
// Define PARAM_ARB_GUARD_EN to block loads for GUARD cycles after each sample_tick_i.
module param_write_arbiter #(
  parameter int N_REQ = 4,
  parameter int DEPTH = 8,
  parameter int WIDTH = 16,
  parameter int GUARD = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int IW = $clog2(N_REQ)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [N_REQ-1:0]       req_i,
  input  logic [N_REQ*AW-1:0]    addr_i,
  input  logic [N_REQ*WIDTH-1:0] wdata_i,
  input  logic                   sample_tick_i,
  output logic [N_REQ-1:0]       gnt_o,
  output logic [DEPTH-1:0]       reg_valid_o,
  output logic [WIDTH-1:0]       reg_data_o,
  output logic                   addr_err_o,
  output logic                   busy_o
);

  typedef enum logic {IDLE, LOAD} state_e;

  state_e           state_q, state_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [IW-1:0]    win_q, win_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [IW-1:0]    pick;
  logic             found;
  int unsigned      scan_idx;
  logic             window_open;
  logic             addr_ok;
  logic             fire;

`ifdef PARAM_ARB_GUARD_EN
  localparam int GW = $clog2(GUARD + 2);
  logic [GW-1:0] guard_cnt_q, guard_cnt_d;

  always_comb begin
    guard_cnt_d = guard_cnt_q;
    if (sample_tick_i)
      guard_cnt_d = GW'(GUARD);
    else if (guard_cnt_q != '0)
      guard_cnt_d = guard_cnt_q - 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) guard_cnt_q <= '0;
    else         guard_cnt_q <= guard_cnt_d;
  end

  // The tick itself closes the window combinationally, even mid-LOAD.
  assign window_open = !sample_tick_i && (guard_cnt_q == '0);
`else
  logic unused_tick;
  int   unused_guard;
  assign unused_tick  = sample_tick_i;
  assign unused_guard = GUARD;
  assign window_open  = 1'b1;
`endif

  assign addr_ok = 32'(addr_q) < 32'(DEPTH);

  // Round-robin search: first asserted request at or above ptr_q, wrapping.
  always_comb begin
    pick     = ptr_q;
    found    = 1'b0;
    scan_idx = 0;
    for (int i = 0; i < N_REQ; i++) begin
      scan_idx = (32'(ptr_q) + 32'(i)) % 32'(N_REQ);
      if (!found && req_i[IW'(scan_idx)]) begin
        found = 1'b1;
        pick  = IW'(scan_idx);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    addr_d  = addr_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          win_d   = pick;
          addr_d  = addr_i[pick*AW +: AW];
          data_d  = wdata_i[pick*WIDTH +: WIDTH];
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (window_open) begin
          ptr_d   = (win_q == IW'(N_REQ - 1)) ? '0 : win_q + 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    fire        = (state_q == LOAD) && window_open;
    busy_o      = (state_q == LOAD);
    reg_data_o  = data_q;
    gnt_o       = '0;
    reg_valid_o = '0;
    addr_err_o  = 1'b0;
    if (fire) begin
      gnt_o = N_REQ'(1) << win_q;
      if (addr_ok) reg_valid_o = DEPTH'(1) << addr_q;
      else         addr_err_o  = 1'b1;
    end
  end

endmodule

// File: tb/tb_param_write_arbiter.sv
// tb/tb_param_write_arbiter.sv - scoreboard bench for param_write_arbiter
module tb_param_write_arbiter;
  localparam int N  = 4;
  localparam int D  = 6;
  localparam int W  = 16;
  localparam int G  = 2;
  localparam int AW = 3;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N*AW-1:0] addr = '0;
  logic [N*W-1:0] wdata = '0;
  logic           sample_tick = 1'b0;
  logic [N-1:0]   gnt;
  logic [D-1:0]   reg_valid;
  logic [W-1:0]   reg_data;
  logic           addr_err;
  logic           busy;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int p;

  typedef struct {
    int         win;
    int         addr;
    logic [W-1:0] data;
    bit         err;
    int         cyc;
  } wr_t;
  wr_t exp_q[$];
  wr_t mon_e;

  param_write_arbiter #(.N_REQ(N), .DEPTH(D), .WIDTH(W), .GUARD(G)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .addr_i(addr), .wdata_i(wdata),
    .sample_tick_i(sample_tick), .gnt_o(gnt), .reg_valid_o(reg_valid),
    .reg_data_o(reg_data), .addr_err_o(addr_err), .busy_o(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] need);
    checks++;
    if (act !== need) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, need, cyc);
    end
  endtask

  // Monitor: any strobe pops one expected write and checks it, including its cycle.
  always @(negedge clk) begin
    if (rst_n && (gnt != '0 || reg_valid != '0 || addr_err)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", 32'({gnt, reg_valid, addr_err}), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("gnt", 32'(gnt), 32'(1) << mon_e.win);
        check("reg_valid", 32'(reg_valid), mon_e.err ? 32'd0 : (32'(1) << mon_e.addr));
        check("reg_data", 32'(reg_data), 32'(mon_e.data));
        check("addr_err", 32'(addr_err), 32'(mon_e.err));
        check("strobe_cycle", cyc, mon_e.cyc);
        check("busy_at_strobe", 32'(busy), 32'd1);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input int a, input logic [W-1:0] d);
    req[i] = 1'b1;
    addr[i*AW +: AW] = 3'(a);
    wdata[i*W +: W] = d;
  endtask

  task automatic expect_wr(input int w, input int a, input logic [W-1:0] d, input bit err, input int c);
    wr_t e;
    e.win = w; e.addr = a; e.data = d; e.err = err; e.cyc = c;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    check({name, "_pending"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    tick();
  endtask

  initial begin
    tick();
    tick();
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_reg_valid", 32'(reg_valid), 32'd0);
    check("rst_addr_err", 32'(addr_err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_reg_data", 32'(reg_data), 32'd0);
    rst_n = 1'b1;
    tick();

    // Single request: strobe one cycle after the sampling edge, busy for that cycle only.
    set_req(2, 3, 16'hA5A5);
    p = cyc;
    expect_wr(2, 3, 16'hA5A5, 1'b0, p + 1);
    check("single_busy_before", 32'(busy), 32'd0);
    tick();
    check("single_busy_load", 32'(busy), 32'd1);
    tick();
    req = '0;
    check("single_busy_after", 32'(busy), 32'd0);
    drain("single");

    // Contention from ptr=0: grants 0,1,2,3,0 every second cycle.
    do_reset();
    set_req(0, 1, 16'h1001);
    set_req(1, 2, 16'h2002);
    set_req(2, 4, 16'h3003);
    set_req(3, 5, 16'h4004);
    p = cyc;
    expect_wr(0, 1, 16'h1001, 1'b0, p + 1);
    expect_wr(1, 2, 16'h2002, 1'b0, p + 3);
    expect_wr(2, 4, 16'h3003, 1'b0, p + 5);
    expect_wr(3, 5, 16'h4004, 1'b0, p + 7);
    expect_wr(0, 1, 16'h1001, 1'b0, p + 9);
    repeat (10) tick();
    req = '0;
    drain("contention");

    // Bad address 7 with DEPTH=6, then ptr=2 must favour requester 2 over 0.
    do_reset();
    set_req(1, 7, 16'hBEEF);
    p = cyc;
    expect_wr(1, 7, 16'hBEEF, 1'b1, p + 1);
    tick();
    tick();
    req[1] = 1'b0;
    set_req(0, 1, 16'h0A0A);
    set_req(2, 2, 16'h0202);
    expect_wr(2, 2, 16'h0202, 1'b0, p + 3);
    expect_wr(0, 1, 16'h0A0A, 1'b0, p + 5);
    tick();
    tick();
    req[2] = 1'b0;
    tick();
    tick();
    req[0] = 1'b0;
    drain("bad_addr");

    // Reset mid-LOAD aborts the write; the held request is regranted from ptr=0.
    do_reset();
    set_req(3, 2, 16'h3333);
    p = cyc;
    tick();
    check("midrst_busy_before", 32'(busy), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_gnt", 32'(gnt), 32'd0);
    check("midrst_reg_valid", 32'(reg_valid), 32'd0);
    check("midrst_addr_err", 32'(addr_err), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_reg_data", 32'(reg_data), 32'd0);
    tick();
    rst_n = 1'b1;
    expect_wr(3, 2, 16'h3333, 1'b0, p + 3);
    tick();
    tick();
    req = '0;
    drain("midrst");

`ifdef PARAM_ARB_GUARD_EN
    // Tick in the first LOAD cycle (t) pushes the strobe to t+3; busy holds meanwhile.
    do_reset();
    set_req(0, 4, 16'h4444);
    p = cyc;
    expect_wr(0, 4, 16'h4444, 1'b0, p + 4);
    tick();
    sample_tick = 1'b1;
    check("guard_busy_t0", 32'(busy), 32'd1);
    tick();
    sample_tick = 1'b0;
    check("guard_busy_t1", 32'(busy), 32'd1);
    tick();
    check("guard_busy_t2", 32'(busy), 32'd1);
    tick();
    check("guard_busy_t3", 32'(busy), 32'd1);
    tick();
    req = '0;
    check("guard_busy_done", 32'(busy), 32'd0);
    drain("guard");
`else
    // Without the guard, a tick every cycle changes nothing.
    do_reset();
    sample_tick = 1'b1;
    set_req(0, 5, 16'h5555);
    p = cyc;
    expect_wr(0, 5, 16'h5555, 1'b0, p + 1);
    expect_wr(0, 5, 16'h5555, 1'b0, p + 3);
    expect_wr(0, 5, 16'h5555, 1'b0, p + 5);
    repeat (6) tick();
    req = '0;
    sample_tick = 1'b0;
    drain("noguard");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
